// File: rtl/serial_full_adder.sv
// Bit-serial adder: {C,S} = A + B + C0, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start, A, B, C0 in;
//        busy, done, S, C out (all registered or decoded from flops).
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_work;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_c;

  logic             w_bit;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_work;
  logic             w_busy;
  logic             w_done;

  // Single full-adder cell on the current LSBs.
  assign w_bit  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout = (r_a[0] & r_b[0])
                | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; the oldest bit drops out of the
  // WIDTH-1 bit holding register on the next shift.
  assign w_work = {w_bit, r_work};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode (from state flops only)
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE:    ;
      RUN:     w_busy = 1'b1;
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_c     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= C0;
            r_work  <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_work  <= w_work[WIDTH-1:1];
          // Count stops at WIDTH-1; it is reloaded on accept.
          if (w_last) begin
            r_s <= w_work;
            r_c <= w_cout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign S    = r_s;
  assign C    = r_c;

endmodule
